// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bus bundle between the register-file write arbiter and its
//               clients (pipeline writeback, MDU, decode hazard lookup).
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  // pipeline writeback
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hold;
  // MDU issue and result
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  // decode hazard lookup
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              hazard;
  // register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // arbiter side
  modport slave (
    input  wb_valid, wb_rd, wb_data,
    output wb_hold,
    input  issue_valid, issue_rd,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    input  rs1_addr, rs2_addr, rd_addr,
    output hazard,
    output rf_we, rf_waddr, rf_wdata
  );

  // client side
  modport master (
    output wb_valid, wb_rd, wb_data,
    input  wb_hold,
    output issue_valid, issue_rd,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    output rs1_addr, rs2_addr, rd_addr,
    input  hazard,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between pipeline
//               writeback (priority) and the MDU. One-entry skid buffer for
//               colliding MDU results, busy scoreboard for MDU destinations,
//               and a writeback-bubble request against MDU starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  wire                  clk,
  input  wire                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int         c_nreg = 1 << ADDR_W;
  localparam logic [3:0] c_max  = 4'(MAX_WAIT);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_buf_rd;
  logic [DATA_W-1:0] r_buf_data;
  logic [c_nreg-1:0] r_busy;
  logic [3:0]        r_cnt;
  logic              r_hold;

  logic              w_hs;
  logic              w_drain;
  logic              w_bypass;
  logic              w_capture;
  logic              w_sel;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [c_nreg-1:0] w_busy_nxt;
  logic [3:0]        w_cnt_nxt;

  assign bus.mdu_ready = (r_state == EMPTY);
  assign w_hs          = bus.mdu_valid & bus.mdu_ready;

  // Write-port source selection: writeback first, then the buffered result,
  // then a direct MDU bypass. An MDU result meeting writeback is buffered.
  always_comb begin
    w_drain   = 1'b0;
    w_bypass  = 1'b0;
    w_capture = 1'b0;
    w_waddr   = bus.wb_rd;
    w_wdata   = bus.wb_data;
    if (bus.wb_valid) begin
      w_capture = w_hs;
    end else if (r_state == FULL) begin
      w_drain = 1'b1;
      w_waddr = r_buf_rd;
      w_wdata = r_buf_data;
    end else if (w_hs) begin
      w_bypass = 1'b1;
      w_waddr  = bus.mdu_rd;
      w_wdata  = bus.mdu_data;
    end
  end

  assign w_sel        = bus.wb_valid | w_drain | w_bypass;
  // x0 writes are suppressed but the transaction itself still completes;
  // the write enable is also held low while reset is asserted.
  assign bus.rf_we    = w_sel & (w_waddr != '0) & reset;
  assign bus.rf_waddr = w_waddr;
  assign bus.rf_wdata = w_wdata;

  // Scoreboard update: MDU commit clears, issue sets (set wins), x0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_drain | w_bypass) begin
      w_busy_nxt[w_waddr] = 1'b0;
    end
    if (bus.issue_valid) begin
      w_busy_nxt[bus.issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Blocked-cycle counter: counts only while a buffered result is held off by
  // writeback, saturates at the limit, and is zero otherwise.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if ((r_state == FULL) && bus.wb_valid) begin
      w_cnt_nxt = (r_cnt == c_max) ? r_cnt : r_cnt + 4'd1;
    end
  end

  assign bus.hazard  = r_busy[bus.rs1_addr] | r_busy[bus.rs2_addr] | r_busy[bus.rd_addr];
  assign bus.wb_hold = r_hold;

  // Buffer state, scoreboard, starvation counter and registered bubble request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_buf_rd   <= '0;
      r_buf_data <= '0;
      r_busy     <= '0;
      r_cnt      <= 4'd0;
      r_hold     <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_capture) begin
            r_state    <= FULL;
            r_buf_rd   <= bus.mdu_rd;
            r_buf_data <= bus.mdu_data;
          end
        end
        FULL: begin
          if (w_drain) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      r_hold <= (w_cnt_nxt == c_max);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter with a
//               write scoreboard of expected register-file writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t q[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid    = 1'b0;
    bus.issue_valid = 1'b0;
    bus.mdu_valid   = 1'b0;
  endtask

  // every observed write must match the oldest expected write
  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.rf_we === 1'b1) begin
      chk1("write_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chkw("wr_addr", 64'(bus.rf_waddr), 64'(e.a));
        chkw("wr_data", bus.rf_wdata, e.d);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    idle();
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.issue_rd = '0;
    bus.mdu_rd   = '0;
    bus.mdu_data = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.rd_addr  = '0;

    // reset: write enable forced low even with a writeback request
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    repeat (2) @(posedge clk);
    #2;
    chk1("rst_we", bus.rf_we, 1'b0);
    idle();
    reset = 1'b1;
    #1;
    chk1("rst_ready", bus.mdu_ready, 1'b1);
    chk1("rst_hold", bus.wb_hold, 1'b0);
    chk1("rst_hazard", bus.hazard, 1'b0);

    // bypass write and hazard window for rd=7
    tick();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1_addr = 5'd7;
    #1 chk1("t1_haz_issue", bus.hazard, 1'b0);
    tick(); idle();
    #1 chk1("t1_haz_busy", bus.hazard, 1'b1);
    tick();
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 64'h1234;
    exp_wr(5'd7, 64'h1234);
    #1;
    chk1("t1_ready", bus.mdu_ready, 1'b1);
    chk1("t1_we", bus.rf_we, 1'b1);
    chk1("t1_haz_wr", bus.hazard, 1'b1);
    tick(); idle();
    #1 chk1("t1_haz_clr", bus.hazard, 1'b0);

    // collision with writeback: rd=3 first, buffered rd=9 next
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick(); idle();
    bus.rs1_addr = 5'd9;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'hAAAA;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 64'h9999;
    exp_wr(5'd3, 64'hAAAA);
    #1 chk1("t2_ready_empty", bus.mdu_ready, 1'b1);
    tick(); idle();
    exp_wr(5'd9, 64'h9999);
    #1;
    chk1("t2_ready_full", bus.mdu_ready, 1'b0);
    chk1("t2_haz_buf", bus.hazard, 1'b1);
    tick();
    #1;
    chk1("t2_ready_back", bus.mdu_ready, 1'b1);
    chk1("t2_haz_clr", bus.hazard, 1'b0);

    // starvation: hold after MAX_WAIT blocked cycles, drop on drain
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 64'h40;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd10; bus.mdu_data = 64'hBEEF;
    exp_wr(5'd4, 64'h40);
    tick();
    bus.mdu_valid = 1'b0;
    for (int i = 1; i <= MW; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(i); bus.wb_data = 64'(100 + i);
      exp_wr(5'(i), 64'(100 + i));
      tick();
      chk1($sformatf("t3_hold_%0d", i), bus.wb_hold, (i == MW));
    end
    bus.wb_valid = 1'b0;
    exp_wr(5'd10, 64'hBEEF);
    #1;
    chk1("t3_ready_full", bus.mdu_ready, 1'b0);
    chk1("t3_hold_up", bus.wb_hold, 1'b1);
    tick();
    chk1("t3_hold_drop", bus.wb_hold, 1'b0);
    chk1("t3_ready_back", bus.mdu_ready, 1'b1);

    // set wins over same-cycle clear, then x0 result
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    tick(); idle();
    bus.rs1_addr = 5'd5;
    #1 chk1("t4_haz_set", bus.hazard, 1'b1);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd5; bus.mdu_data = 64'h55;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    exp_wr(5'd5, 64'h55);
    tick(); idle();
    #1 chk1("t4_set_wins", bus.hazard, 1'b1);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd5; bus.mdu_data = 64'h66;
    exp_wr(5'd5, 64'h66);
    tick(); idle();
    #1 chk1("t4_haz_clr", bus.hazard, 1'b0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6; bus.rs1_addr = 5'd6;
    tick(); idle();
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 64'hFF;
    #1;
    chk1("t4_x0_we", bus.rf_we, 1'b0);
    chk1("t4_x0_ready", bus.mdu_ready, 1'b1);
    tick(); idle();
    #1;
    chk1("t4_x0_accepted", bus.mdu_ready, 1'b1);
    chk1("t4_x0_busy6", bus.hazard, 1'b1);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd6; bus.mdu_data = 64'h6;
    exp_wr(5'd6, 64'h6);
    tick(); idle();

    // reset while FULL with busy[12] and wb_hold raised
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    tick(); idle();
    bus.rs1_addr = 5'd12;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 64'h22;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 64'hC0C0;
    exp_wr(5'd2, 64'h22);
    tick();
    bus.mdu_valid = 1'b0;
    for (int i = 1; i <= MW; i++) begin
      bus.wb_rd = 5'd2; bus.wb_data = 64'(200 + i);
      exp_wr(5'd2, 64'(200 + i));
      tick();
    end
    chk1("t5_ready_full", bus.mdu_ready, 1'b0);
    chk1("t5_haz_busy", bus.hazard, 1'b1);
    chk1("t5_hold_up", bus.wb_hold, 1'b1);
    idle();
    reset = 1'b0;
    #1;
    chk1("t5_rst_we", bus.rf_we, 1'b0);
    chk1("t5_rst_ready", bus.mdu_ready, 1'b1);
    chk1("t5_rst_haz", bus.hazard, 1'b0);
    chk1("t5_rst_hold", bus.wb_hold, 1'b0);
    tick(); tick();
    reset = 1'b1;
    repeat (4) tick();
    chk1("t5_haz_after", bus.hazard, 1'b0);
    chkw("pending_writes", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- Keeps a per-register busy scoreboard for outstanding MDU destinations, so decode can stall on RAW and WAW hazards.
- Holds one colliding MDU result in a skid buffer.
- Prevents MDU starvation by requesting a one-cycle writeback bubble.

Parameters:
- DATA_W, 64, register data width.
- ADDR_W, 5, register address width (32 registers).
- MAX_WAIT, 4, consecutive blocked cycles before wb_hold is raised; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline writeback request; always has priority, never back-pressured
- wb_rd  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline result
- wb_hold  out  1  registered request that the pipeline insert a writeback bubble
- issue_valid  in  1  long-latency op issued to MDU this cycle
- issue_rd  in  ADDR_W  destination of the issued op
- mdu_valid  in  1  MDU result available
- mdu_rd  in  ADDR_W  MDU result destination
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  arbiter accepts an MDU result
- rs1_addr, rs2_addr, rd_addr  in  ADDR_W  decode-stage register addresses
- hazard  out  1  a decode address hits a busy register
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

Behaviour:
- Reset (reset=0, async): clears busy[31:0], buffer-valid bit, wait counter and wb_hold to 0. rf_we is forced to 0 while reset is low. mdu_ready=1 after release.
- State is two-state, EMPTY / FULL (buffer-valid bit), plus a 4-bit wait counter.
- mdu_ready = !buf_full, combinational. An MDU handshake is mdu_valid & mdu_ready.
- Write-port selection (combinational, priority order):
  1. wb_valid: the port carries wb_rd/wb_data.
  2. Else buffer FULL: the port carries the buffered rd/data. The buffer goes EMPTY at the edge.
  3. Else MDU handshake: bypass, the port carries mdu_rd/mdu_data directly.
  4. Else rf_we=0.
- rf_we=0 whenever the selected rd==0, but the x0 transaction still completes (buffer still drains, handshake still accepted).
- MDU handshake while wb_valid=1: the result is captured into the buffer (EMPTY->FULL), with no write that cycle. The handshake cannot coincide with FULL because mdu_ready=0.
- Latency: bypass writes in the handshake cycle. A buffered result writes in the first later cycle with wb_valid=0.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the edge.
  - A committed MDU write clears busy[rd] at the edge ending the write cycle (bypass or drain).
  - busy[0] is constantly 0.
  - If set and clear target the same register in the same cycle, set wins.
- hazard = busy[rs1_addr] | busy[rs2_addr] | busy[rd_addr], combinational. Issuing to an already-busy rd is illegal; decode prevents it using hazard.
- Starvation:
  - While FULL and wb_valid=1, the counter increments (saturating at MAX_WAIT).
  - When the counter reaches MAX_WAIT, wb_hold=1 from the next edge.
  - The pipeline guarantees wb_valid=0 within one cycle of wb_hold=1. The buffer drains that cycle.
  - On drain (FULL->EMPTY) the counter clears and wb_hold deasserts at the same edge.
  - The counter also clears whenever EMPTY.
- Reset mid-operation: buffered data is discarded, all busy bits clear, wb_hold drops immediately.

Test Plan:
- Reset, then issue rd=7; MDU returns rd=7 data=0x1234 with wb_valid=0 -> rf_we=1 in the handshake cycle with waddr=7 and wdata=0x1234. hazard for rs1=7 is 1 from issue+1 until the edge after the write.
- MDU rd=9 handshake while wb_valid=1 (rd=3) -> port writes rd=3. mdu_ready=0 next cycle. With wb_valid=0 on the following cycle, rd=9 is written and mdu_ready returns to 1.
- Buffer FULL, wb_valid held at 1 with MAX_WAIT=4 -> wb_hold rises after 4 blocked cycles. Pipeline drops wb_valid -> buffered write occurs, and wb_hold and counter are 0 at the next edge.
- issue rd=5 in the same cycle as an MDU commit to rd=5 -> busy[5] remains 1. MDU result rd=0 -> rf_we=0, handshake accepted, no busy change.
- Assert reset while FULL with busy[12]=1 -> mdu_ready=1, busy all 0, wb_hold=0, and no write to rd 12 after release.
